aes256_m_axis_adapter: RTL and testbench

- Output-side stream adapter for the aes256 core.
- The core presents results as a valid-only stream (data valid, tlast, 128-bit data) with no backpressure. This block buffers those results in a FIFO and re-presents them as an AXI4-Stream master (tvalid/tready/tlast/tdata) toward downstream logic.
- It also tracks blocks in flight inside the core and issues a credit signal. The upstream source gates s_axis_tvalid with this credit, so accepted blocks can never overflow the FIFO.

---
 rtl/aes256_m_axis_adapter_if.sv | 9 +
 rtl/aes256_m_axis_adapter.sv | 60 ++++++
 tb/tb_aes256_m_axis_adapter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes256_m_axis_adapter_if.sv
// aes256_m_axis_adapter_if: AXI4-Stream bundle between the adapter and downstream logic.
interface aes256_m_axis_adapter_if #(parameter int DATA_W = 128);
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata;
   modport master (output tvalid, output tlast, output tdata, input tready);
   modport slave (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/aes256_m_axis_adapter.sv
// aes256_m_axis_adapter: buffers valid-only core results in a FWFT FIFO and re-presents them as AXI4-Stream with credit flow control.
// Optional sticky overflow flag and assertion: AES_OUT_OVERFLOW_CHK_EN.
module aes256_m_axis_adapter #(
   parameter int DEPTH      = 8,
   parameter int DATA_W     = 128,
   parameter int INFLIGHT_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pi_issue,
   input  logic                    pi_data_valid,
   input  logic                    pi_data_tlast,
   input  logic [DATA_W-1:0]       pi_data,
   output logic                    po_issue_allow,
   aes256_m_axis_adapter_if.master m_axis,
   output logic [INFLIGHT_W-1:0]   po_fill_level,
   output logic                    po_overflow
);
   localparam int PW = $clog2(DEPTH);
   logic [DATA_W:0]         mem [DEPTH];
   logic [PW-1:0]           wp, rp;
   logic [INFLIGHT_W-1:0]   occ, infl;
   logic                    full, rd, wr;
   assign full  = occ == INFLIGHT_W'(DEPTH);
   assign rd    = m_axis.tvalid & m_axis.tready;
   assign wr    = pi_data_valid & (~full | rd);
   assign m_axis.tvalid = occ != '0;
   assign m_axis.tdata  = m_axis.tvalid ? mem[rp][DATA_W-1:0] : '0;
   assign m_axis.tlast  = m_axis.tvalid & mem[rp][DATA_W];
   assign po_fill_level = occ;
   // Credit uses registered counters only, so no input reaches it combinationally.
   assign po_issue_allow = ({1'b0, occ} + {1'b0, infl}) < (INFLIGHT_W + 1)'(DEPTH);
   always_ff @(posedge clk)
      if (wr) mem[wp] <= {pi_data_tlast, pi_data};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp   <= '0;
         rp   <= '0;
         occ  <= '0;
         infl <= '0;
      end else begin
         if (wr) wp <= wp + PW'(1);
         if (rd) rp <= rp + PW'(1);
         if (wr && !rd) occ <= occ + INFLIGHT_W'(1);
         else if (rd && !wr) occ <= occ - INFLIGHT_W'(1);
         if (pi_issue && !pi_data_valid) infl <= infl + INFLIGHT_W'(1);
         else if (pi_data_valid && !pi_issue && infl != '0) infl <= infl - INFLIGHT_W'(1);
      end
`ifdef AES_OUT_OVERFLOW_CHK_EN
   logic err, ovf;
   assign err = (pi_data_valid & full & ~rd) | (pi_data_valid & ~pi_issue & (infl == '0));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ovf <= 1'b0;
      else ovf <= ovf | err;
   assign po_overflow = ovf;
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !err);
`else
   assign po_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_aes256_m_axis_adapter.sv
// tb_aes256_m_axis_adapter: scoreboard bench with a queue-level reference model of the adapter.
module tb_aes256_m_axis_adapter;
   localparam int DEPTH = 8;
`ifdef AES_OUT_OVERFLOW_CHK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic pi_issue = 1'b0, pi_data_valid = 1'b0, pi_data_tlast = 1'b0;
   logic [127:0] pi_data = '0;
   logic po_issue_allow, po_overflow;
   logic [4:0] po_fill_level;
   aes256_m_axis_adapter_if #(.DATA_W(128)) m ();
   aes256_m_axis_adapter dut (
      .clk(clk), .rst_n(rst_n), .pi_issue(pi_issue), .pi_data_valid(pi_data_valid),
      .pi_data_tlast(pi_data_tlast), .pi_data(pi_data), .po_issue_allow(po_issue_allow),
      .m_axis(m.master), .po_fill_level(po_fill_level), .po_overflow(po_overflow));
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   logic [128:0] sb [$];
   int occ = 0, infl = 0;
   bit ovf = 1'b0;
   logic [127:0] vec [4];
   task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic check_state();
      chk("fill", 129'(po_fill_level), 129'(occ));
      chk("tvalid", 129'(m.tvalid), 129'(occ != 0));
      chk("credit", 129'(po_issue_allow), 129'((occ + infl) < DEPTH));
      chk("overflow", 129'(po_overflow), 129'(ovf));
      if (occ == 0) chk("idle_data", {m.tlast, m.tdata}, '0);
   endtask
   // One clock: drive inputs, predict the queue/counter update, then check.
   task automatic step(input logic iss, input logic v, input logic l, input logic [127:0] d, input logic rdy);
      bit rd, wr;
      pi_issue = iss; pi_data_valid = v; pi_data_tlast = l; pi_data = d; m.tready = rdy;
      rd = (occ != 0) && rdy;
      wr = v && (occ < DEPTH || rd);
      if (wr) sb.push_back({l, d});
      if (OVF_EN && ((v && !wr) || (v && !iss && infl == 0))) ovf = 1'b1;
      @(posedge clk); #1;
      occ = occ + int'(wr) - int'(rd);
      if (iss && !v) infl++;
      else if (v && !iss && infl > 0) infl--;
      check_state();
   endtask
   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, rdy);
   endtask
   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   // Monitor: every visible word must match the scoreboard head; it pops on handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n && m.tvalid) begin
         if (sb.size() == 0) chk("unexpected_word", {m.tlast, m.tdata}, '0);
         else begin
            chk("word", {m.tlast, m.tdata}, sb[0]);
            if (m.tready) void'(sb.pop_front());
         end
      end
   end
   initial begin
      int n;
      vec[0] = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
      vec[1] = 128'h591CCB10D410ED26DC5BA74A31362870;
      vec[2] = 128'hB6ED21B99CA6F4F9F153E7B1BEAFED1D;
      vec[3] = 128'h23304B7A39F9F3FF067D8D8F9E24ECC7;
      m.tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state();
      rst_n = 1'b1;
      #1;
      check_state();
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 1'b0, vec[0], 1'b1);
      idle(1'b1, 2);
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, vec[i], 1'b1);
      step(1'b0, 1'b1, 1'b1, vec[3], 1'b1);
      idle(1'b1, 2);
      n = 0;
      for (int i = 0; i < 20 && po_issue_allow; i++) begin
         step(1'b1, 1'b0, 1'b0, '0, 1'b0);
         n++;
      end
      chk("accepted_issues", 129'(n), 129'(DEPTH));
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i[0], rnd(), 1'b0);
      chk("full_fill", 129'(po_fill_level), 129'(DEPTH));
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, rnd(), 1'b1);
      step(1'b0, 1'b1, 1'b1, rnd(), 1'b0);
      idle(1'b0, 2);
      idle(1'b1, DEPTH + 2);
      chk("drained", 129'(sb.size()), '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, rnd(), 1'b0);
      rst_n = 1'b0;
      #1;
      sb.delete(); occ = 0; infl = 0; ovf = 1'b0;
      check_state();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 1'b1, vec[3], 1'b1);
      idle(1'b1, 2);
      for (int i = 0; i < 400; i++) begin
         logic iss, v;
         iss = ((occ + infl) < DEPTH) && ($urandom_range(0, 2) != 0);
         v = (infl > 0) && ($urandom_range(0, 2) != 0);
         step(iss, v, 1'($urandom), rnd(), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 4 * DEPTH && (occ != 0 || infl != 0); i++)
         step(1'b0, infl > 0, 1'b0, rnd(), 1'b1);
      idle(1'b1, 2);
      chk("final_drain", 129'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
